sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
- Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
- Sits directly upstream of sevenseg_hex: selects one 4-bit nibble per time slot and presents it on digit_data, which feeds sevenseg_hex.data.
- Drives active-low anode enables and the decimal point, with a dead-time between digits to prevent ghosting.
- Snapshots display data once per frame so the display never tears.

Parameters:
- DIGITS, 8: number of digits scanned (2..8).
- PRESCALE, 100000: clk cycles per digit slot (>= 2).
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off (must be < PRESCALE).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 blanks the display and restarts the scan.
- data_in  in  4*DIGITS  packed nibbles; digit i = data_in[4i+3:4i], digit 0 rightmost.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- blank_in  in  DIGITS  force digit off, active-high.
- digit_data  out  4  nibble to sevenseg_hex.data.
- an_l  out  DIGITS  anode enables, active-low.
- dp_l  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values (asynchronous):
  - an_l = all 1; dp_l = 1; digit_data = 0; frame_start = 0.
  - Slot counter cnt = 0; digit index idx = 0; shadow registers = 0; state = SCAN_DEAD.
  - Reset mid-frame has the same effect.
- Counters:
  - cnt counts 0..PRESCALE-1 while en=1.
  - At cnt = PRESCALE-1: cnt wraps to 0 and idx advances; idx wraps DIGITS-1 -> 0.
- Snapshot:
  - In any en=1 cycle with cnt=0 and idx=0, load data_in, dp_in and blank_in into the shadow registers.
  - In that same edge, frame_start is registered high for exactly one cycle.
  - Inputs are ignored at all other times.
- States: SCAN_DEAD when cnt < DEAD_CYCLES, otherwise SCAN_DRIVE.
- Outputs: all outputs are registered and reflect the cnt/idx/shadow values of the previous cycle (one-cycle latency).
  - digit_data = shadow nibble[idx] in both states; it changes during dead-time only.
  - an_l:
    - SCAN_DEAD: all 1.
    - SCAN_DRIVE: bit idx = 0 unless shadow_blank[idx]; all other bits 1.
  - dp_l = ~shadow_dp[idx] when the digit is driven; otherwise 1.
- en=0: next edge forces an_l all 1, dp_l = 1, cnt = 0, idx = 0, frame_start = 0. The shadow registers hold their values.
- Re-enable: the first en=1 cycle takes a fresh snapshot and begins the digit 0 slot.
- Full frame = DIGITS*PRESCALE cycles; frame_start period equals the frame length.
- Invariant: at most one an_l bit is low at any time.

Optional Feature:
- Macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
- Defined: each digit above the most significant nonzero shadow nibble is additionally blanked (an_l held 1, dp_l held 1).
  - Digit 0 is never blanked by this rule.
  - Computed combinationally from the shadow registers, so it stays stable for the whole frame.
- Undefined: only blank_in controls blanking; no extra logic is synthesized.

Decomposition:
- Package sevenseg_pkg:
  - scan_state_t enum {SCAN_DEAD, SCAN_DRIVE}.
  - NIBBLE_W = 4.
  - Function onehot_low(idx, width) returning the active-low anode vector.
- Sub-module sevenseg_slot_timer: holds the cnt/idx counters and wrap logic.
  - Outputs idx, slot_start (cnt==0), dead.
  - Shares the same clk, reset_n and en.

Test Plan (bench params DIGITS=4, PRESCALE=4, DEAD_CYCLES=1; outputs feed a sevenseg_hex instance):
1. Reset:
   - Stimulus: assert reset_n=0 mid-slot while an_l=1101.
   - Required: immediately an_l=1111, dp_l=1, digit_data=0, frame_start=0. After release with en=1, frame_start pulses on the first edge.
2. Scan order:
   - Stimulus: data_in=16'h1234, en=1.
   - Required per slot: one dead cycle with an_l=1111, then three cycles at an_l=1110 with digit_data=4. Then 1101/3, 1011/2, 0111/1. frame_start repeats every 16 cycles.
3. Snapshot:
   - Stimulus: change data_in to 16'hABCD during the digit 1 slot.
   - Required: current frame finishes showing 2 and 1; next frame shows D, C, B, A.
4. Blank and decimal point:
   - Stimulus: blank_in=4'b0100, dp_in=4'b0001.
   - Required: an_l stays 1111 for the whole digit 2 slot; dp_l=0 only in the three drive cycles of digit 0.
5. Enable drop:
   - Stimulus: en=0 for 2 cycles during the digit 2 slot.
   - Required: an_l=1111 on the next edge. On re-enable, frame_start pulses and the scan restarts at digit 0 with the new data_in.
6. Macro SEVENSEG_LEADING_ZERO_BLANK_EN, data_in=16'h0050:
   - Defined: digit 3 and digit 2 slots keep an_l=1111; digit 1 shows 5; digit 0 shows 0.
   - Undefined: all four digits are driven.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package sevenseg_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        SCAN_DEAD  = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    // Active-low anode vector with only bit idx low; bits at or above width stay 1.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx, input int width);
        logic [MAX_DIGITS-1:0] v;
        v = '1;
        if (int'(idx) < width) v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Slot timer: cnt counts cycles within a digit slot, idx selects the digit.
// Both restart from zero whenever en is low.
module sevenseg_slot_timer #(
    parameter int DIGITS      = 8,
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    output logic [$clog2(DIGITS)-1:0] idx,
    output logic                      slot_start,
    output logic                      dead
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    // Slot counter with digit advance on wrap; disable restarts the scan at digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign idx        = r_idx;
    assign slot_start = (r_cnt == '0);
    assign dead       = (r_cnt < DEAD_LIM);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Snapshots the inputs once per frame, drives one digit per slot with a
// leading dead-time, and registers every output.
// Optional: define SEVENSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [NIBBLE_W*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          blank_in,
    output logic [NIBBLE_W-1:0]        digit_data,
    output logic [DIGITS-1:0]          an_l,
    output logic                       dp_l,
    output logic                       frame_start
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [IDX_W-1:0] w_idx;
    logic             w_slot_start;
    logic             w_dead;
    logic             w_snap;

    sevenseg_slot_timer #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .idx        (w_idx),
        .slot_start (w_slot_start),
        .dead       (w_dead)
    );

    // A new frame begins in the first cycle of the digit 0 slot.
    assign w_snap = en & w_slot_start & (w_idx == '0);

    logic [NIBBLE_W*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]          r_sh_dp;
    logic [DIGITS-1:0]          r_sh_blank;

    // Frame shadow: inputs are captured only at frame start so the display never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
        end else if (w_snap) begin
            r_sh_data  <= data_in;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank_in;
        end
    end

    // In the snapshot cycle the fresh inputs bypass the shadow, so the digit 0
    // nibble lands on digit_data during its dead-time rather than at drive start.
    logic [NIBBLE_W*DIGITS-1:0]        w_eff_data;
    logic [DIGITS-1:0]                 w_eff_dp;
    logic [DIGITS-1:0]                 w_eff_blank;
    logic [DIGITS-1:0][NIBBLE_W-1:0]   w_nib;
    logic [DIGITS-1:0]                 w_blank_all;

    assign w_eff_data  = w_snap ? data_in  : r_sh_data;
    assign w_eff_dp    = w_snap ? dp_in    : r_sh_dp;
    assign w_eff_blank = w_snap ? blank_in : r_sh_blank;
    assign w_nib       = w_eff_data;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_lz;

    // Digit i (i > 0) is a leading zero when it and every digit above it are zero.
    always_comb begin : lz_calc
        logic v_zero;
        w_lz   = '0;
        v_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_zero  = v_zero & (w_nib[i] == '0);
            w_lz[i] = v_zero;
        end
    end

    assign w_blank_all = w_eff_blank | w_lz;
`else
    assign w_blank_all = w_eff_blank;
`endif

    logic [MAX_DIGITS-1:0] w_oh8;
    logic [DIGITS-1:0]     w_an_drive;
    scan_state_t           w_state;

    assign w_oh8      = onehot_low(3'(w_idx), DIGITS);
    assign w_an_drive = w_oh8[DIGITS-1:0];
    assign w_state    = w_dead ? SCAN_DEAD : SCAN_DRIVE;

    logic [NIBBLE_W-1:0] r_digit;
    logic [DIGITS-1:0]   r_an_l;
    logic                r_dp_l;
    logic                r_frame_start;

    // Registered outputs: dead-time keeps all anodes off, drive enables one anode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit       <= '0;
            r_an_l        <= '1;
            r_dp_l        <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (!en) begin
            r_an_l        <= '1;
            r_dp_l        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            r_digit       <= w_nib[w_idx];
            case (w_state)
                SCAN_DRIVE: begin
                    if (w_blank_all[w_idx]) begin
                        r_an_l <= '1;
                        r_dp_l <= 1'b1;
                    end else begin
                        r_an_l <= w_an_drive;
                        r_dp_l <= ~w_eff_dp[w_idx];
                    end
                end
                default: begin
                    r_an_l <= '1;
                    r_dp_l <= 1'b1;
                end
            endcase
        end
    end

    assign digit_data  = r_digit;
    assign an_l        = r_an_l;
    assign dp_l        = r_dp_l;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (DIGITS=4, PRESCALE=4, DEAD_CYCLES=1).
// Expected per-cycle outputs are queued frame by frame and popped after each edge.
module tb_sevenseg_scan;

    localparam int DIGITS      = 4;
    localparam int PRESCALE    = 4;
    localparam int DEAD_CYCLES = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  digit_data;
    logic [3:0]  an_l;
    logic        dp_l;
    logic        frame_start;

    sevenseg_scan #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .digit_data  (digit_data),
        .an_l        (an_l),
        .dp_l        (dp_l),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] dd;
        logic       dp;
        logic       fs;
        logic       chk_dd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Queue the expected output sequence of one full frame showing d.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        logic [3:0] off;
        logic       z;
        exp_t       x;
        off = bl;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        for (int k = 1; k < 4; k++) begin
            z = 1'b1;
            for (int j = k; j < 4; j++) if (d[4*j +: 4] != 4'h0) z = 1'b0;
            if (z) off[k] = 1'b1;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            x.an = 4'hF; x.dd = d[4*k +: 4]; x.dp = 1'b1; x.fs = (k == 0); x.chk_dd = 1'b0;
            q.push_back(x);
            repeat (PRESCALE - DEAD_CYCLES) begin
                x.an     = off[k] ? 4'hF : ~(4'b0001 << k);
                x.dp     = off[k] ? 1'b1 : ~dp[k];
                x.fs     = 1'b0;
                x.chk_dd = 1'b1;
                q.push_back(x);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; data_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        #12;
        n_chk++;
        if (an_l !== 4'hF || dp_l !== 1'b1 || digit_data !== 4'h0 || frame_start !== 1'b0)
            $display("FAIL reset_initial: an_l=%b dp_l=%b dd=%h fs=%b, required 1111/1/0/0", an_l, dp_l, digit_data, frame_start);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1; en = 1'b1; data_in = 16'h1234;
        push_frame(16'h1234, 4'h0, 4'h0);
        // run into the digit 1 drive (an_l=1101), then reset mid-slot
        repeat (6) begin
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL reset_run: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL reset_run: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (an_l !== 4'hF || dp_l !== 1'b1 || digit_data !== 4'h0 || frame_start !== 1'b0)
            $display("FAIL reset_midslot: an_l=%b dp_l=%b dd=%h fs=%b, required 1111/1/0/0", an_l, dp_l, digit_data, frame_start);
        else n_pass++;
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        push_frame(16'h1234, 4'h0, 4'h0);
        repeat (16) begin
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL reset_restart: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL reset_restart: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_scan_order();
        data_in = 16'h1234;
        push_frame(16'h1234, 4'h0, 4'h0);
        push_frame(16'h1234, 4'h0, 4'h0);
        repeat (32) begin
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL scan_order: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL scan_order: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_snapshot();
        push_frame(16'h1234, 4'h0, 4'h0);
        push_frame(16'hABCD, 4'h0, 4'h0);
        for (int c = 0; c < 32; c++) begin
            if (c == 6) data_in = 16'hABCD;   // during the digit 1 slot
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL snapshot: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL snapshot: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank_dp();
        blank_in = 4'b0100; dp_in = 4'b0001;
        push_frame(16'hABCD, 4'b0001, 4'b0100);
        for (int c = 0; c < 16; c++) begin
            if (c == 1) begin blank_in = 4'h0; dp_in = 4'h0; end  // shadow must keep them
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL blank_dp: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL blank_dp: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable_drop();
        push_frame(16'hABCD, 4'h0, 4'h0);
        repeat (10) begin   // ends on the first drive cycle of digit 2
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL en_drop_pre: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL en_drop_pre: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
        q.delete();
        en = 1'b0; data_in = 16'h5678;
        repeat (2) begin
            @(posedge clk); #1;
            n_chk++;
            if (an_l !== 4'hF || dp_l !== 1'b1 || frame_start !== 1'b0)
                $display("FAIL en_drop_off: an_l=%b dp_l=%b fs=%b, required 1111/1/0", an_l, dp_l, frame_start);
            else n_pass++;
        end
        en = 1'b1;
        push_frame(16'h5678, 4'h0, 4'h0);
        repeat (16) begin
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL en_drop_resume: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL en_drop_resume: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    task automatic test_leading_zero();
        data_in = 16'h0050;
        push_frame(16'h0050, 4'h0, 4'h0);
        repeat (16) begin
            @(posedge clk); #1;
            n_chk++;
            if (q.size() == 0) $display("FAIL leading_zero: queue empty");
            else begin
                e = q.pop_front();
                if (an_l !== e.an || dp_l !== e.dp || frame_start !== e.fs || (e.chk_dd && digit_data !== e.dd))
                    $display("FAIL leading_zero: got an_l=%b dp_l=%b dd=%h fs=%b, expected an_l=%b dp_l=%b dd=%h fs=%b",
                             an_l, dp_l, digit_data, frame_start, e.an, e.dp, e.dd, e.fs);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_snapshot();
        test_blank_dp();
        test_enable_drop();
        test_leading_zero();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
